// File: rtl/rf_pkg.sv
// Shared register-file constants and the writeback request record
// used by every source that targets the register file write port.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after
// ptr_i (wrapping) wins; produces one-hot grant plus its index.
module rr_arbiter #(
    parameter int  NUM_REQ = 3,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_any_o
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0]     pos;
    logic               found;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;

    always_comb begin
        pos       = '0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr < NUM_REQ and k < NUM_REQ, so one subtraction wraps it
            pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (pos >= N_W) begin
                pos = pos - N_W;
            end
            if (!found && req_i[pos[IDX_W-1:0]]) begin
                found                    = 1'b1;
                grant[pos[IDX_W-1:0]]    = 1'b1;
                grant_idx                = pos[IDX_W-1:0];
            end
        end
    end

    assign grant_o     = grant;
    assign grant_idx_o = grant_idx;
    assign grant_any_o = found;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port among NUM_REQ writeback sources,
// each with a one-entry holding buffer, through a registered write stage.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int  NUM_REQ = 3,
    parameter int  DATA_W  = REG_DATA_W,
    parameter int  ADDR_W  = REG_ADDR_W,
    localparam int IDX_W   = $clog2(NUM_REQ),
    localparam int NREGS   = 2 ** ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      regWrite,
    output logic [ADDR_W-1:0]         writeReg,
    output logic [DATA_W-1:0]         writeData,
    output logic [NREGS-1:0]          pending_mask,
    output logic [IDX_W-1:0]          grant_id
);

    logic [NUM_REQ-1:0] buf_valid_q;
    logic [ADDR_W-1:0]  buf_reg_q  [NUM_REQ];
    logic [DATA_W-1:0]  buf_data_q [NUM_REQ];
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_reg_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic [IDX_W-1:0]   grant_id_q;

    logic [NUM_REQ-1:0] grant_oh;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               do_grant;
    logic [NUM_REQ-1:0] xfer;
    logic [NREGS-1:0]   pend_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i       (buf_valid_q),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant_oh),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    // Ready comes only from registered state; a granted buffer can be refilled on the same edge.
    assign req_ready = ~buf_valid_q | grant_oh;
    assign do_grant  = grant_any & ~flush;
    assign xfer      = req_valid & req_ready & {NUM_REQ{~flush}};
    assign rr_ptr_d  = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= '0;
            rr_ptr_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            grant_id_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_reg_q[i]  <= '0;
                buf_data_q[i] <= '0;
            end
        end else begin
            wr_en_q <= 1'b0;
            if (do_grant) begin
                // r0 writes are consumed but never enabled, keeping the hardwired zero
                wr_en_q    <= (buf_reg_q[grant_idx] != ADDR_W'(REG_ZERO));
                wr_reg_q   <= buf_reg_q[grant_idx];
                wr_data_q  <= buf_data_q[grant_idx];
                grant_id_q <= grant_idx;
                rr_ptr_q   <= rr_ptr_d;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush) begin
                    buf_valid_q[i] <= 1'b0;
                end else if (xfer[i]) begin
                    buf_valid_q[i] <= 1'b1;
                    buf_reg_q[i]   <= req_reg[i*ADDR_W +: ADDR_W];
                    buf_data_q[i]  <= req_data[i*DATA_W +: DATA_W];
                end else if (grant_oh[i]) begin
                    buf_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        pend_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (buf_valid_q[i]) begin
                pend_d[buf_reg_q[i]] = 1'b1;
            end
        end
        if (wr_en_q) begin
            pend_d[wr_reg_q] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    assign pending_mask = pend_d;
    assign regWrite     = wr_en_q;
    assign writeReg     = wr_reg_q;
    assign writeData    = wr_data_q;
    assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a per-cycle vector table plus
// hand-written fairness and flush-with-staged-write sequences.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_reg;
    logic [95:0] req_data;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [31:0] pending_mask;
    logic [1:0]  grant_id;

    wb_req_t     reqs [3];
    logic [31:0] mem [32] = '{default: 32'h0};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_reg  = '0;
        req_data = '0;
        for (int i = 0; i < 3; i++) begin
            req_reg[i*5 +: 5]   = reqs[i].dst;
            req_data[i*32 +: 32] = reqs[i].data;
        end
    end

    // Register file the arbiter feeds
    always @(posedge clk) begin
        if (regWrite) mem[writeReg] <= writeData;
    end

    rf_write_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_reg      (req_reg),
        .req_data     (req_data),
        .regWrite     (regWrite),
        .writeReg     (writeReg),
        .writeData    (writeData),
        .pending_mask (pending_mask),
        .grant_id     (grant_id)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic [2:0]  valid;
        logic [4:0]  r0, r1, r2;
        logic [31:0] d0, d1, d2;
        logic        e_we;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic [1:0]  e_gid;
        logic [2:0]  e_rdy;
        logic [31:0] e_pm;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mkv(
        input logic rs, input logic fl, input logic [2:0] v,
        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
        input logic we, input logic [4:0] wr, input logic [31:0] wd,
        input logic [1:0] gid, input logic [2:0] rdy, input logic [31:0] pm);
        vec_t t;
        t.rst = rs; t.flush = fl; t.valid = v;
        t.r0 = r0; t.r1 = r1; t.r2 = r2;
        t.d0 = d0; t.d1 = d1; t.d2 = d2;
        t.e_we = we; t.e_wr = wr; t.e_wd = wd;
        t.e_gid = gid; t.e_rdy = rdy; t.e_pm = pm;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
        reqs[i].dst  = r;
        reqs[i].data = d;
    endtask

    int cnt [3];

    initial begin
        //                rst fl valid   r0 r1 r2  d0            d1            d2            we wr wd            gid rdy     pm
        vecs[0]  = mkv(1, 0, 3'b111, 1, 2, 3, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        0, 3'b111, 32'h0);
        vecs[1]  = mkv(1, 0, 3'b111, 1, 2, 3, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        0, 3'b111, 32'h0);
        vecs[2]  = mkv(0, 0, 3'b111, 1, 2, 3, 32'h11111111, 32'h22222222, 32'h33333333, 0, 0, 32'h0,        0, 3'b001, 32'h0000000E);
        vecs[3]  = mkv(0, 0, 3'b000, 1, 2, 3, 32'h11111111, 32'h22222222, 32'h33333333, 1, 1, 32'h11111111, 0, 3'b011, 32'h0000000E);
        vecs[4]  = mkv(0, 0, 3'b000, 1, 2, 3, 32'h11111111, 32'h22222222, 32'h33333333, 1, 2, 32'h22222222, 1, 3'b111, 32'h0000000C);
        vecs[5]  = mkv(0, 0, 3'b000, 1, 2, 3, 32'h11111111, 32'h22222222, 32'h33333333, 1, 3, 32'h33333333, 2, 3'b111, 32'h00000008);
        vecs[6]  = mkv(0, 0, 3'b001, 5, 0, 0, 32'hDEADBEEF, 32'h0,        32'h0,        0, 3, 32'h33333333, 2, 3'b111, 32'h00000020);
        vecs[7]  = mkv(0, 0, 3'b000, 5, 0, 0, 32'hDEADBEEF, 32'h0,        32'h0,        1, 5, 32'hDEADBEEF, 0, 3'b111, 32'h00000020);
        vecs[8]  = mkv(0, 0, 3'b000, 5, 0, 0, 32'hDEADBEEF, 32'h0,        32'h0,        0, 5, 32'hDEADBEEF, 0, 3'b111, 32'h0);
        vecs[9]  = mkv(0, 0, 3'b010, 0, 0, 0, 32'h0,        32'hFFFFFFFF, 32'h0,        0, 5, 32'hDEADBEEF, 0, 3'b111, 32'h0);
        vecs[10] = mkv(0, 0, 3'b000, 0, 0, 0, 32'h0,        32'hFFFFFFFF, 32'h0,        0, 0, 32'hFFFFFFFF, 1, 3'b111, 32'h0);
        vecs[11] = mkv(0, 0, 3'b011, 7, 9, 0, 32'h77777777, 32'h99999999, 32'h0,        0, 0, 32'hFFFFFFFF, 1, 3'b101, 32'h00000280);
        vecs[12] = mkv(0, 1, 3'b000, 7, 9, 0, 32'h77777777, 32'h99999999, 32'h0,        0, 0, 32'hFFFFFFFF, 1, 3'b111, 32'h0);
        vecs[13] = mkv(0, 0, 3'b000, 7, 9, 0, 32'h77777777, 32'h99999999, 32'h0,        0, 0, 32'hFFFFFFFF, 1, 3'b111, 32'h0);
        vecs[14] = mkv(0, 0, 3'b011, 7, 9, 0, 32'h77777777, 32'h99999999, 32'h0,        0, 0, 32'hFFFFFFFF, 1, 3'b101, 32'h00000280);
        vecs[15] = mkv(0, 0, 3'b000, 7, 9, 0, 32'h77777777, 32'h99999999, 32'h0,        1, 7, 32'h77777777, 0, 3'b111, 32'h00000280);
        vecs[16] = mkv(1, 0, 3'b000, 7, 9, 0, 32'h77777777, 32'h99999999, 32'h0,        0, 0, 32'h0,        0, 3'b111, 32'h0);

        rst = 1'b1; flush = 1'b0; req_valid = 3'b000;
        for (int i = 0; i < 3; i++) set_req(i, 5'd0, 32'h0);

        for (int i = 0; i < 17; i++) begin
            rst       = vecs[i].rst;
            flush     = vecs[i].flush;
            req_valid = vecs[i].valid;
            set_req(0, vecs[i].r0, vecs[i].d0);
            set_req(1, vecs[i].r1, vecs[i].d1);
            set_req(2, vecs[i].r2, vecs[i].d2);
            step();
            chk($sformatf("v%0d.regWrite", i),     64'(regWrite),     64'(vecs[i].e_we));
            chk($sformatf("v%0d.writeReg", i),     64'(writeReg),     64'(vecs[i].e_wr));
            chk($sformatf("v%0d.writeData", i),    64'(writeData),    64'(vecs[i].e_wd));
            chk($sformatf("v%0d.grant_id", i),     64'(grant_id),     64'(vecs[i].e_gid));
            chk($sformatf("v%0d.req_ready", i),    64'(req_ready),    64'(vecs[i].e_rdy));
            chk($sformatf("v%0d.pending_mask", i), 64'(pending_mask), 64'(vecs[i].e_pm));
            if (i == 13) begin
                chk("flush.mem7", 64'(mem[7]), 64'h0);
                chk("flush.mem9", 64'(mem[9]), 64'h0);
            end
        end
        chk("rst.mem9", 64'(mem[9]), 64'h0);
        chk("r0.mem0",  64'(mem[0]), 64'h0);

        // Fairness: all three sources held valid for 30 grant cycles
        rst = 1'b0; flush = 1'b0;
        set_req(0, 5'd10, 32'hA0);
        set_req(1, 5'd11, 32'hA1);
        set_req(2, 5'd12, 32'hA2);
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        step();
        for (int c = 0; c < 30; c++) begin
            step();
            chk($sformatf("fair%0d.regWrite", c), 64'(regWrite), 64'h1);
            chk($sformatf("fair%0d.grant_id", c), 64'(grant_id), 64'(c % 3));
            chk($sformatf("fair%0d.writeData", c), 64'(writeData), 64'(32'hA0 + 32'(c % 3)));
            if (grant_id < 2'd3) cnt[grant_id]++;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fair.count%0d", i), 64'(cnt[i]), 64'd10);
        end

        // Flush while a write is staged: the staged write still commits
        req_valid = 3'b000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 5'd20, 32'hCAFEF00D);
        req_valid = 3'b001;
        step();
        req_valid = 3'b000;
        step();
        chk("stg.regWrite", 64'(regWrite), 64'h1);
        chk("stg.writeReg", 64'(writeReg), 64'd20);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("stgflush.regWrite", 64'(regWrite), 64'h0);
        chk("stgflush.pending",  64'(pending_mask), 64'h0);
        chk("stgflush.mem20",    64'(mem[20]), 64'hCAFEF00D);
        step();
        chk("end.mem0", 64'(mem[0]), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
